// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and helpers for the io bus arbiter: FSM state encoding,
// the read-data fill value returned on a forced completion, and index wrap helpers.
package io_bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic TIMEOUT_FILL_BIT = 1'b1;

  // Operands are always below n, so a single conditional subtract wraps correctly.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

  function automatic int rr_next(input int idx, input int n);
    return wrap_add(idx, 1, n);
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Strobe-based io bus bundle; N_PORTS > 1 packs several requesters side by side,
// with requester 0 in the lowest slice of every packed vector.
interface io_bus_arbiter_if #(
  parameter int N_PORTS = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N_PORTS-1:0]        addr_strobe;
  logic [N_PORTS-1:0]        read_strobe;
  logic [N_PORTS-1:0]        write_strobe;
  logic [N_PORTS*ADDR_W-1:0] addr;
  logic [N_PORTS*BE_W-1:0]   byte_enable;
  logic [N_PORTS*DATA_W-1:0] write_data;
  logic [DATA_W-1:0]         read_data;
  logic [N_PORTS-1:0]        ready;

  modport master (
    output addr_strobe, read_strobe, write_strobe, addr, byte_enable, write_data,
    input  read_data, ready
  );

  modport slave (
    input  addr_strobe, read_strobe, write_strobe, addr, byte_enable, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping
// from N-1 back to 0. Returns both a one-hot grant and its index.
module rr_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin : pick
    int j;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = wrap_add(int'(ptr), k, N);
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one strobe-based io bus between N_MASTERS requesters with round-robin replay.
// Optional IO_BUS_TIMEOUT_EN: forced completion after TIMEOUT cycles in WAIT.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  io_bus_arbiter_if.slave  m,
  io_bus_arbiter_if.master s,
  output logic            timeout_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(N_MASTERS);

  state_t state_q, state_d;

  logic [N_MASTERS-1:0] pending;
  logic [N_MASTERS-1:0] capture;
  logic [N_MASTERS-1:0] complete_oh;
  logic [N_MASTERS-1:0] arb_gnt;
  logic [N_MASTERS-1:0] grant_oh_q;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     rr_ptr;
  logic                 arb_valid;
  logic                 issue;
  logic                 complete;
  logic                 timeout_hit;

  logic [ADDR_W-1:0]    cap_addr  [N_MASTERS];
  logic [BE_W-1:0]      cap_be    [N_MASTERS];
  logic [DATA_W-1:0]    cap_wdata [N_MASTERS];
  logic [N_MASTERS-1:0] cap_rd;
  logic [N_MASTERS-1:0] cap_wr;

  // A master finishing this cycle may strobe again; the set must beat the clear.
  assign capture = m.addr_strobe & (~pending | complete_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      cap_rd  <= '0;
      cap_wr  <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        cap_addr[i]  <= '0;
        cap_be[i]    <= '0;
        cap_wdata[i] <= '0;
      end
    end else begin
      pending <= (pending & ~complete_oh) | capture;
      for (int i = 0; i < N_MASTERS; i++) begin
        if (capture[i]) begin
          cap_addr[i]  <= m.addr[i*ADDR_W +: ADDR_W];
          cap_be[i]    <= m.byte_enable[i*BE_W +: BE_W];
          cap_wdata[i] <= m.write_data[i*DATA_W +: DATA_W];
          cap_rd[i]    <= m.read_strobe[i];
          cap_wr[i]    <= m.write_strobe[i];
        end
      end
    end
  end

  rr_arbiter #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (pending),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = WAIT;
      WAIT:    if (complete)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completion is returned combinationally, and only to the master that owns the bus.
  always_comb begin
    issue       = 1'b0;
    complete    = 1'b0;
    complete_oh = '0;
    m.ready     = '0;
    m.read_data = '0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: issue = arb_valid;
      WAIT: begin
        if (s.ready[0] || timeout_hit) begin
          complete    = 1'b1;
          complete_oh = grant_oh_q;
          m.ready     = grant_oh_q;
          m.read_data = timeout_hit ? {DATA_W{TIMEOUT_FILL_BIT}} : s.read_data;
          timeout_err = timeout_hit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.addr_strobe  <= '0;
      s.read_strobe  <= '0;
      s.write_strobe <= '0;
      s.addr         <= '0;
      s.byte_enable  <= '0;
      s.write_data   <= '0;
      grant_q        <= '0;
      grant_oh_q     <= '0;
      rr_ptr         <= '0;
    end else begin
      s.addr_strobe  <= '0;
      s.read_strobe  <= '0;
      s.write_strobe <= '0;
      if (issue) begin
        s.addr_strobe  <= 1'b1;
        s.read_strobe  <= cap_rd[arb_idx];
        s.write_strobe <= cap_wr[arb_idx];
        s.addr         <= cap_addr[arb_idx];
        s.byte_enable  <= cap_be[arb_idx];
        s.write_data   <= cap_wdata[arb_idx];
        grant_q        <= arb_idx;
        grant_oh_q     <= arb_gnt;
      end
      if (complete) begin
        rr_ptr <= IDX_W'(rr_next(int'(grant_q), N_MASTERS));
      end
    end
  end

`ifdef IO_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts WAIT cycles already spent, so it reads TIMEOUT-1 during the TIMEOUT-th one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_q == WAIT && !complete) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (state_q == WAIT) && !s.ready[0] &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed sequences, a vector table of
// arbitration scenarios, and randomized traffic against a transaction-level model.
module tb_io_bus_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic timeout_err;

  always #5 clk = ~clk;

  io_bus_arbiter_if #(.N_PORTS(NM), .ADDR_W(AW), .DATA_W(DW)) mif ();
  io_bus_arbiter_if #(.N_PORTS(1),  .ADDR_W(AW), .DATA_W(DW)) sif ();

  io_bus_arbiter #(
    .N_MASTERS (NM),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m           (mif),
    .s           (sif),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [NM-1:0] req;
    logic [NM-1:0] wr;
    int            delay;
    int            n_srv;
    int            first;
    int            second;
    logic [DW-1:0] rdata;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] pay_addr [NM];
  logic [BW-1:0] pay_be   [NM];
  logic [DW-1:0] pay_wd   [NM];
  logic [NM-1:0] pay_wr;

  // Reference model: per-master request slots plus the single outstanding transfer.
  bit   [NM-1:0] md_pend;
  logic [AW-1:0] md_addr [NM];
  logic [BW-1:0] md_be   [NM];
  logic [DW-1:0] md_wd   [NM];
  bit   [NM-1:0] md_wr;
  int            md_rr, md_grant, md_wcnt;
  bit            md_busy, md_done, md_to;
  bit            ex_stb, ex_rd, ex_wr;
  logic [AW-1:0] ex_addr;
  logic [BW-1:0] ex_be;
  logic [DW-1:0] ex_wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setInputs(input logic [NM-1:0] req, input logic [NM-1:0] wr);
    logic [NM*AW-1:0] a;
    logic [NM*BW-1:0] b;
    logic [NM*DW-1:0] d;
    for (int i = 0; i < NM; i++) begin
      a[i*AW +: AW] = pay_addr[i];
      b[i*BW +: BW] = pay_be[i];
      d[i*DW +: DW] = pay_wd[i];
    end
    mif.addr         = a;
    mif.byte_enable  = b;
    mif.write_data   = d;
    mif.addr_strobe  = req;
    mif.write_strobe = req & wr;
    mif.read_strobe  = req & ~wr;
    pay_wr           = (pay_wr & ~req) | (wr & req);
  endtask

  task automatic applyStimulus(input logic [NM-1:0] req, input logic [NM-1:0] wr);
    setInputs(req, wr);
    tick();
    setInputs('0, '0);
  endtask

  // Leaves time at the sampling point of the cycle where the downstream strobe is seen.
  task automatic waitStrobe(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      #3;
      if (sif.addr_strobe[0] === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen) checkOutput("strobe_wait", 64'd0, 64'd1);
  endtask

  task automatic serveOne(input int mi, input logic [DW-1:0] rdata, input int delay);
    bit seen;
    waitStrobe(seen);
    if (!seen) return;
    checkOutput($sformatf("s_addr_m%0d", mi), sif.addr, pay_addr[mi]);
    checkOutput($sformatf("s_be_m%0d", mi), sif.byte_enable, pay_be[mi]);
    checkOutput($sformatf("s_wdata_m%0d", mi), sif.write_data, pay_wd[mi]);
    checkOutput($sformatf("s_rw_m%0d", mi), {sif.read_strobe, sif.write_strobe},
                {~pay_wr[mi], pay_wr[mi]});
    for (int d = 0; d < delay; d++) begin
      checkOutput("m_ready_early", mif.ready, '0);
      tick();
      #3;
    end
    sif.read_data = rdata;
    sif.ready     = 1'b1;
    #1;
    checkOutput($sformatf("m_ready_m%0d", mi), mif.ready, NM'(1) << mi);
    checkOutput($sformatf("m_rdata_m%0d", mi), mif.read_data, rdata);
    tick();
    sif.ready     = 1'b0;
    sif.read_data = '0;
  endtask

  task automatic modelReset();
    md_pend = '0; md_wr = '0; md_rr = 0; md_grant = 0; md_wcnt = 0; md_busy = 0;
    ex_stb = 0; ex_rd = 0; ex_wr = 0; ex_addr = '0; ex_be = '0; ex_wd = '0;
    for (int i = 0; i < NM; i++) begin
      md_addr[i] = '0; md_be[i] = '0; md_wd[i] = '0;
    end
  endtask

  task automatic modelCheck();
    logic [NM-1:0] exp_m;
    logic [DW-1:0] exp_d;
    md_to = 1'b0;
`ifdef IO_BUS_TIMEOUT_EN
    md_to = md_busy && !sif.ready[0] && (md_wcnt == TO);
`endif
    md_done = md_busy && (sif.ready[0] || md_to);
    exp_m   = md_done ? (NM'(1) << md_grant) : '0;
    exp_d   = !md_done ? '0 : (md_to ? {DW{1'b1}} : sif.read_data);
    checkOutput("rand_s_side",
                {sif.addr_strobe, sif.read_strobe, sif.write_strobe, sif.addr, sif.byte_enable},
                {ex_stb, ex_rd, ex_wr, ex_addr, ex_be});
    checkOutput("rand_s_wdata", sif.write_data, ex_wd);
    checkOutput("rand_m_side", {timeout_err, mif.ready, mif.read_data}, {md_to, exp_m, exp_d});
  endtask

  task automatic modelStep(input logic [NM-1:0] req, input logic [NM-1:0] wr);
    bit [NM-1:0] old_pend;
    bit          found;
    int          g;
    old_pend = md_pend;
    ex_stb = 0; ex_rd = 0; ex_wr = 0;
    if (md_done) begin
      md_pend[md_grant] = 1'b0;
      md_rr   = (md_grant + 1) % NM;
      md_busy = 1'b0;
    end else if (md_busy) begin
      md_wcnt++;
    end else if (old_pend != '0) begin
      found = 1'b0;
      for (int k = 0; k < NM; k++) begin
        g = (md_rr + k) % NM;
        if (!found && old_pend[g]) begin
          found    = 1'b1;
          md_grant = g;
        end
      end
      md_busy = 1'b1;
      md_wcnt = 1;
      ex_stb  = 1'b1;
      ex_rd   = !md_wr[md_grant];
      ex_wr   = md_wr[md_grant];
      ex_addr = md_addr[md_grant];
      ex_be   = md_be[md_grant];
      ex_wd   = md_wd[md_grant];
    end
    for (int i = 0; i < NM; i++) begin
      if (req[i] && (!old_pend[i] || (md_done && md_grant == i))) begin
        md_pend[i] = 1'b1;
        md_addr[i] = pay_addr[i];
        md_be[i]   = pay_be[i];
        md_wd[i]   = pay_wd[i];
        md_wr[i]   = wr[i];
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          vecs [5];
    bit            seen, any;
    logic [NM-1:0] req, wr;

    for (int i = 0; i < NM; i++) begin
      pay_addr[i] = '0; pay_be[i] = '0; pay_wd[i] = '0;
    end
    pay_wr = '0;
    setInputs('0, '0);
    sif.ready     = 1'b0;
    sif.read_data = '0;

    #2;
    checkOutput("reset_s", {sif.addr_strobe, sif.read_strobe, sif.write_strobe,
                            sif.addr, sif.byte_enable, sif.write_data}, '0);
    checkOutput("reset_m", {timeout_err, mif.ready, mif.read_data}, '0);
    tick();
    rst_n = 1'b1;

    // Two-cycle latency from master strobe to downstream strobe.
    pay_addr[0] = 32'h100; pay_be[0] = 4'hF; pay_wd[0] = 32'h0;
    applyStimulus(2'b01, 2'b00);
    #3;
    checkOutput("latency_early", sif.addr_strobe, 1'b0);
    tick();
    #3;
    checkOutput("latency_2cyc", {sif.addr_strobe, sif.read_strobe, sif.addr}, {2'b11, 32'h100});
    tick();
    #3;
    sif.read_data = 32'hA5A5A5A5;
    sif.ready     = 1'b1;
    #1;
    checkOutput("first_ready", mif.ready, 2'b01);
    checkOutput("first_rdata", mif.read_data, 32'hA5A5A5A5);
    tick();
    sif.ready = 1'b0;

    // Re-strobe in the completion cycle is kept and replayed after one idle cycle.
    applyStimulus(2'b01, 2'b00);
    waitStrobe(seen);
    sif.ready     = 1'b1;
    sif.read_data = 32'h77;
    pay_addr[0]   = 32'h200;
    setInputs(2'b01, 2'b00);
    #1;
    checkOutput("b2b_ready", mif.ready, 2'b01);
    tick();
    setInputs('0, '0);
    sif.ready = 1'b0;
    #3;
    checkOutput("b2b_idle_gap", sif.addr_strobe, 1'b0);
    tick();
    #3;
    checkOutput("b2b_second", {sif.addr_strobe, sif.addr}, {1'b1, 32'h200});
    sif.ready = 1'b1;
    tick();
    sif.ready = 1'b0;

    // A strobe while the slot is still pending is dropped.
    pay_addr[0] = 32'h300;
    applyStimulus(2'b01, 2'b00);
    pay_addr[0] = 32'h304;
    applyStimulus(2'b01, 2'b00);
    pay_addr[0] = 32'h300;
    serveOne(0, 32'h88, 1);
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      any |= sif.addr_strobe[0];
      tick();
    end
    checkOutput("violation_dropped", any, 1'b0);

    // Reset while a transfer is outstanding.
    pay_addr[0] = 32'h400; pay_wd[0] = 32'hDEAD;
    applyStimulus(2'b01, 2'b01);
    waitStrobe(seen);
    tick();
    #1;
    rst_n     = 1'b0;
    sif.ready = 1'b1;
    #1;
    checkOutput("rst_wait_s", {sif.addr_strobe, sif.read_strobe, sif.write_strobe,
                               sif.addr, sif.write_data}, '0);
    checkOutput("rst_wait_m", {timeout_err, mif.ready, mif.read_data}, '0);
    tick();
    rst_n = 1'b1;
    any   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      any |= (|mif.ready) | sif.addr_strobe[0];
      tick();
    end
    checkOutput("rst_no_ready", any, 1'b0);
    sif.ready = 1'b0;

    // Arbitration scenarios applied in order from a fresh pointer.
    vecs[0] = '{2'b01, 2'b00, 2, 1, 0, 0, 32'hA5A5A5A5};
    vecs[1] = '{2'b11, 2'b10, 0, 2, 1, 0, 32'h11112222};
    vecs[2] = '{2'b10, 2'b10, 1, 1, 1, 0, 32'h00000000};
    vecs[3] = '{2'b11, 2'b01, 0, 2, 0, 1, 32'h33334444};
    vecs[4] = '{2'b11, 2'b00, 3, 2, 0, 1, 32'h55556666};
    pay_addr[0] = 32'h100; pay_be[0] = 4'hF;    pay_wd[0] = 32'hCAFE0000;
    pay_addr[1] = 32'h20;  pay_be[1] = 4'b0011; pay_wd[1] = 32'h1234;
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].req, vecs[v].wr);
      serveOne(vecs[v].first, vecs[v].rdata, vecs[v].delay);
      if (vecs[v].n_srv == 2) serveOne(vecs[v].second, vecs[v].rdata, vecs[v].delay);
    end

    // No downstream completion: forced completion when enabled, otherwise wait forever.
    pay_addr[1] = 32'h40;
    applyStimulus(2'b10, 2'b00);
    waitStrobe(seen);
    any = 1'b0;
`ifdef IO_BUS_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      any |= (|mif.ready) | timeout_err;
      tick();
      #3;
    end
    checkOutput("timeout_early", any, 1'b0);
    checkOutput("timeout_fire", {timeout_err, mif.ready, mif.read_data}, {1'b1, 2'b10, 32'hFFFFFFFF});
    tick();
    sif.ready     = 1'b1;
    sif.read_data = 32'h99;
    #3;
    checkOutput("timeout_late_ready", mif.ready, 2'b00);
    tick();
    sif.ready = 1'b0;
`else
    for (int c = 0; c < 12; c++) begin
      any |= (|mif.ready) | timeout_err;
      tick();
      #3;
    end
    checkOutput("no_timeout", any, 1'b0);
    sif.ready     = 1'b1;
    sif.read_data = 32'h99;
    #1;
    checkOutput("late_ready", {timeout_err, mif.ready, mif.read_data}, {1'b0, 2'b10, 32'h99});
    tick();
    sif.ready = 1'b0;
`endif

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    modelReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NM; i++) begin
        req[i]      = ($urandom_range(3) == 0);
        wr[i]       = 1'($urandom_range(1));
        pay_addr[i] = $urandom;
        pay_be[i]   = 4'($urandom);
        pay_wd[i]   = $urandom;
      end
      setInputs(req, wr);
      sif.ready     = ($urandom_range(2) == 0);
      sif.read_data = $urandom;
      #3;
      modelCheck();
      modelStep(req, wr);
      tick();
    end
    setInputs('0, '0);
    sif.ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
